// File: rtl/ordered_release_multi.sv
// Re-ordering buffer: gathers serial-tagged records from NUM_CH lanes and
// releases them strictly in serial order on one valid/ready output stream.
module ordered_release_multi #(
  parameter int DATA_WIDTH    = 128,
  parameter int NUM_CH        = 8,
  parameter int SN_WIDTH      = 32,
  parameter int DEPTH         = 4,
  parameter bit EMIT_UNJOINED = 1'b0
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH*SN_WIDTH-1:0]   in_serialnum,
  input  logic [NUM_CH-1:0]            in_joined,
  input  logic [NUM_CH-1:0]            in_last_processed,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SN_WIDTH-1:0]          out_serialnum,
  output logic                         out_joined,
  output logic                         out_last,
  output logic [SN_WIDTH-1:0]          next_sn
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;
  state_e state_q, state_d;

  logic [NUM_CH-1:0][DEPTH-1:0] valid_q, valid_d;
  logic [NUM_CH-1:0][CW-1:0]    count_q, count_d;
  logic [NUM_CH-1:0]            last_q;
  logic [SN_WIDTH-1:0]          next_sn_q, next_sn_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_joined_q, out_joined_d;
  logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
  logic [SN_WIDTH-1:0]          out_sn_q, out_sn_d;

  logic [SN_WIDTH-1:0]          sn_q   [NUM_CH][DEPTH];
  logic [DATA_WIDTH-1:0]        data_q [NUM_CH][DEPTH];
  logic [NUM_CH-1:0][DEPTH-1:0] joined_q;

  logic [NUM_CH-1:0] wr_en;
  logic [SW-1:0]     wr_slot [NUM_CH];
  logic              hit, dup, emit, can_load, load, release_en, all_empty;
  logic [LW-1:0]     hit_c;
  logic [SW-1:0]     hit_s;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      in_ready[c] = (count_q[c] < CW'(DEPTH)) && (state_q != DONE);
    end
  end
  assign wr_en = in_valid & in_ready;

  // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wr_slot[c] = '0;
      for (int s = DEPTH - 1; s >= 0; s--) begin
        if (!valid_q[c][s]) wr_slot[c] = SW'(s);
      end
    end
  end

  // Priority search: lowest lane first, then lowest slot; a second match is a protocol error.
  always_comb begin
    hit   = 1'b0;
    dup   = 1'b0;
    hit_c = '0;
    hit_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int s = 0; s < DEPTH; s++) begin
        if (valid_q[c][s] && (sn_q[c][s] == next_sn_q)) begin
          if (hit) begin
            dup = 1'b1;
          end else begin
            hit   = 1'b1;
            hit_c = LW'(c);
            hit_s = SW'(s);
          end
        end
      end
    end
  end

  assign can_load   = !out_valid_q || out_ready;
  assign emit       = hit && (joined_q[hit_c][hit_s] || EMIT_UNJOINED);
  assign load       = emit && can_load && (state_q != DONE);
  assign release_en = hit && (state_q != DONE) && (can_load || !emit);

  always_comb begin
    valid_d      = valid_q;
    count_d      = count_q;
    all_empty    = 1'b1;
    next_sn_d    = next_sn_q + SN_WIDTH'(release_en);
    out_valid_d  = out_valid_q && !out_ready;
    out_data_d   = out_data_q;
    out_sn_d     = out_sn_q;
    out_joined_d = out_joined_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en[c]) valid_d[c][wr_slot[c]] = 1'b1;
      count_d[c] = count_q[c] + CW'(wr_en[c]) - CW'(release_en && (hit_c == LW'(c)));
      if (count_q[c] != '0) all_empty = 1'b0;
    end
    if (release_en) valid_d[hit_c][hit_s] = 1'b0;
    if (load) begin
      out_valid_d  = 1'b1;
      out_data_d   = data_q[hit_c][hit_s];
      out_sn_d     = sn_q[hit_c][hit_s];
      out_joined_d = joined_q[hit_c][hit_s];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (&last_q) state_d = DRAIN;
      DRAIN:   if (all_empty && !out_valid_q && !(|wr_en)) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= RUN;
      valid_q      <= '0;
      count_q      <= '0;
      last_q       <= '0;
      next_sn_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sn_q     <= '0;
      out_joined_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      last_q       <= last_q | in_last_processed;
      next_sn_q    <= next_sn_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sn_q     <= out_sn_d;
      out_joined_q <= out_joined_d;
    end
  end

  // NOTE: payload storage is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en[c]) begin
        sn_q[c][wr_slot[c]]     <= in_serialnum[c*SN_WIDTH +: SN_WIDTH];
        data_q[c][wr_slot[c]]   <= in_data[c*DATA_WIDTH +: DATA_WIDTH];
        joined_q[c][wr_slot[c]] <= in_joined[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (!dup) else $error("ordered_release_multi: serial %0d stored twice", next_sn_q);
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_serialnum = out_sn_q;
  assign out_joined    = out_joined_q;
  assign out_last      = (state_q == DONE);
  assign next_sn       = next_sn_q;

endmodule

// File: tb/tb_ordered_release_multi.sv
// Scoreboard bench for ordered_release_multi: a retire-mode instance (A) and
// an emit-mode instance (B), both with 4-bit serials so wrap is reachable.
module tb_ordered_release_multi;
  localparam int DW  = 16;
  localparam int NCH = 8;
  localparam int SNW = 4;
  localparam int DEP = 4;

  typedef struct packed {
    logic [SNW-1:0] sn;
    logic           joined;
    logic [DW-1:0]  data;
  } rec_t;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic [NCH-1:0]     in_valid_a, in_valid_b, in_joined, in_last;
  logic [NCH*DW-1:0]  in_data;
  logic [NCH*SNW-1:0] in_sn;
  logic               out_ready;

  logic [NCH-1:0] a_in_ready, b_in_ready;
  logic           a_out_valid, a_out_joined, a_out_last, b_out_valid, b_out_joined, b_out_last;
  logic [DW-1:0]  a_out_data, b_out_data;
  logic [SNW-1:0] a_out_sn, a_next_sn, b_out_sn, b_next_sn;

  rec_t q_a[$];
  rec_t q_b[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  ordered_release_multi #(.DATA_WIDTH(DW), .NUM_CH(NCH), .SN_WIDTH(SNW), .DEPTH(DEP),
                          .EMIT_UNJOINED(1'b0)) dut_a (
    .clk(clk), .resetn(resetn), .in_valid(in_valid_a), .in_ready(a_in_ready),
    .in_data(in_data), .in_serialnum(in_sn), .in_joined(in_joined),
    .in_last_processed(in_last), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_serialnum(a_out_sn), .out_joined(a_out_joined),
    .out_last(a_out_last), .next_sn(a_next_sn));

  ordered_release_multi #(.DATA_WIDTH(DW), .NUM_CH(NCH), .SN_WIDTH(SNW), .DEPTH(DEP),
                          .EMIT_UNJOINED(1'b1)) dut_b (
    .clk(clk), .resetn(resetn), .in_valid(in_valid_b), .in_ready(b_in_ready),
    .in_data(in_data), .in_serialnum(in_sn), .in_joined(in_joined),
    .in_last_processed(in_last), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_serialnum(b_out_sn), .out_joined(b_out_joined),
    .out_last(b_out_last), .next_sn(b_next_sn));

  function automatic logic [DW-1:0] mk_data(input int lane, input int sn);
    return DW'(32'hA000 + lane * 256 + sn);
  endfunction

  function automatic rec_t mk_rec(input int lane, input int sn, input bit j);
    rec_t r;
    r.sn     = SNW'(sn);
    r.joined = j;
    r.data   = mk_data(lane, sn);
    return r;
  endfunction

  // Output monitors: every handshake pops and compares the head of the scoreboard.
  always @(negedge clk) begin
    rec_t got;
    rec_t exp;
    if (resetn && a_out_valid && out_ready) begin
      n_checks++;
      got = {a_out_sn, a_out_joined, a_out_data};
      if (q_a.size() == 0) begin
        $display("FAIL mon_a: got unexpected record %h, expected none", got);
      end else begin
        exp = q_a.pop_front();
        if (got !== exp) $display("FAIL mon_a: got %h expected %h", got, exp);
        else n_pass++;
      end
    end
    if (resetn && b_out_valid && out_ready) begin
      n_checks++;
      got = {b_out_sn, b_out_joined, b_out_data};
      if (q_b.size() == 0) begin
        $display("FAIL mon_b: got unexpected record %h, expected none", got);
      end else begin
        exp = q_b.pop_front();
        if (got !== exp) $display("FAIL mon_b: got %h expected %h", got, exp);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_valid();
    in_valid_a = '0;
    in_valid_b = '0;
  endtask

  task automatic set_lane(input int lane, input int sn, input bit j, input bit to_b);
    in_sn[lane*SNW +: SNW]  = SNW'(sn);
    in_data[lane*DW +: DW]  = mk_data(lane, sn);
    in_joined[lane]         = j;
    if (to_b) in_valid_b[lane] = 1'b1;
    else      in_valid_a[lane] = 1'b1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_valid();
    in_last   = '0;
    in_joined = '0;
    out_ready = 1'b0;
    q_a.delete();
    q_b.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    logic [34:0] got;
    clear_valid();
    in_last = '0; in_joined = '0; in_data = '0; in_sn = '0; out_ready = 1'b0;
    #1 resetn = 1'b0;
    #1;
    got = {a_out_valid, a_out_last, a_out_data, a_out_sn, a_out_joined, a_next_sn, a_in_ready};
    n_checks++;
    if (got !== {1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 8'hFF})
      $display("FAIL reset_in: got %h expected %h", got, {1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 8'hFF});
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    tick();
    got = {a_out_valid, a_out_last, a_out_data, a_out_sn, a_out_joined, a_next_sn, a_in_ready};
    n_checks++;
    if (got !== {1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 8'hFF})
      $display("FAIL reset_out: got %h expected %h", got, {1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 8'hFF});
    else n_pass++;
  endtask

  task automatic test_reorder();
    do_reset();
    out_ready = 1'b1;
    q_a.push_back(mk_rec(7, 0, 1'b1));
    q_a.push_back(mk_rec(2, 1, 1'b1));
    q_a.push_back(mk_rec(0, 2, 1'b1));
    q_a.push_back(mk_rec(5, 3, 1'b1));
    set_lane(5, 3, 1'b1, 1'b0);
    set_lane(2, 1, 1'b1, 1'b0);
    set_lane(7, 0, 1'b1, 1'b0);
    set_lane(0, 2, 1'b1, 1'b0);
    tick();
    clear_valid();
    n_checks++;
    if (a_out_valid !== 1'b0) $display("FAIL reorder_latency: out_valid got %b expected 0", a_out_valid);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (a_out_valid !== 1'b1 || a_out_sn !== SNW'(i))
        $display("FAIL reorder_seq[%0d]: got valid=%b sn=%0d expected valid=1 sn=%0d", i, a_out_valid, a_out_sn, i);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (a_out_valid !== 1'b0 || a_next_sn !== 4'd4)
      $display("FAIL reorder_end: got valid=%b next_sn=%0d expected valid=0 next_sn=4", a_out_valid, a_next_sn);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) q_a.push_back(mk_rec(1, i, 1'b1));
    for (int k = 0; k < 4; k++) begin
      clear_valid();
      set_lane(1, 3 - k, 1'b1, 1'b0);
      tick();
    end
    clear_valid();
    n_checks++;
    if (a_in_ready[1] !== 1'b0 || a_out_valid !== 1'b0)
      $display("FAIL bp_full: got ready1=%b valid=%b expected ready1=0 valid=0", a_in_ready[1], a_out_valid);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (a_out_valid !== 1'b1 || a_out_sn !== 4'd0 || a_out_data !== mk_data(1, 0) || a_in_ready[1] !== 1'b1)
        $display("FAIL bp_hold[%0d]: got valid=%b sn=%0d data=%h ready1=%b expected 1/0/%h/1",
                 k, a_out_valid, a_out_sn, a_out_data, a_in_ready[1], mk_data(1, 0));
      else n_pass++;
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      n_checks++;
      if (a_out_valid !== 1'b1 || a_out_sn !== SNW'(i))
        $display("FAIL bp_release[%0d]: got valid=%b sn=%0d expected valid=1 sn=%0d", i, a_out_valid, a_out_sn, i);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (a_out_valid !== 1'b0 || a_next_sn !== 4'd4)
      $display("FAIL bp_end: got valid=%b next_sn=%0d expected valid=0 next_sn=4", a_out_valid, a_next_sn);
    else n_pass++;
  endtask

  task automatic run_joined(input bit use_b);
    logic [5:0]     jp;
    logic           ov, oj, ev;
    logic [SNW-1:0] osn, nsn;
    jp = 6'b101001;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (use_b) q_b.push_back(mk_rec(i, i, jp[i]));
      else if (jp[i]) q_a.push_back(mk_rec(i, i, jp[i]));
      set_lane(i, i, jp[i], use_b);
    end
    tick();
    clear_valid();
    for (int k = 0; k < 6; k++) begin
      tick();
      ov  = use_b ? b_out_valid  : a_out_valid;
      osn = use_b ? b_out_sn     : a_out_sn;
      oj  = use_b ? b_out_joined : a_out_joined;
      nsn = use_b ? b_next_sn    : a_next_sn;
      ev  = use_b ? 1'b1 : jp[k];
      n_checks++;
      if (ov !== ev || (ev && (osn !== SNW'(k) || oj !== jp[k])))
        $display("FAIL joined_out[b=%0d,%0d]: got valid=%b sn=%0d joined=%b expected valid=%b sn=%0d joined=%b",
                 use_b, k, ov, osn, oj, ev, k, jp[k]);
      else n_pass++;
      n_checks++;
      if (nsn !== SNW'(k + 1))
        $display("FAIL joined_next_sn[b=%0d,%0d]: got %0d expected %0d", use_b, k, nsn, k + 1);
      else n_pass++;
    end
    tick();
    ov = use_b ? b_out_valid : a_out_valid;
    n_checks++;
    if (ov !== 1'b0) $display("FAIL joined_end[b=%0d]: got valid=%b expected 0", use_b, ov);
    else n_pass++;
  endtask

  task automatic test_retire();
    run_joined(1'b0);
  endtask

  task automatic test_emit();
    run_joined(1'b1);
  endtask

  task automatic test_wrap();
    int order[4];
    order = '{14, 15, 0, 1};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      q_a.push_back(mk_rec(i % 8, i, 1'b1));
      clear_valid();
      set_lane(i % 8, i, 1'b1, 1'b0);
      tick();
    end
    clear_valid();
    for (int k = 0; k < 10 && a_next_sn !== 4'd14; k++) tick();
    n_checks++;
    if (a_next_sn !== 4'd14) $display("FAIL wrap_preload: got next_sn=%0d expected 14", a_next_sn);
    else n_pass++;
    q_a.push_back(mk_rec(1, 14, 1'b1));
    q_a.push_back(mk_rec(0, 15, 1'b1));
    q_a.push_back(mk_rec(2, 0, 1'b1));
    q_a.push_back(mk_rec(3, 1, 1'b1));
    set_lane(0, 15, 1'b1, 1'b0);
    set_lane(1, 14, 1'b1, 1'b0);
    set_lane(2, 0, 1'b1, 1'b0);
    set_lane(3, 1, 1'b1, 1'b0);
    tick();
    clear_valid();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (a_out_valid !== 1'b1 || a_out_sn !== SNW'(order[k]))
        $display("FAIL wrap_seq[%0d]: got valid=%b sn=%0d expected valid=1 sn=%0d", k, a_out_valid, a_out_sn, order[k]);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (a_out_valid !== 1'b0 || a_next_sn !== 4'd2)
      $display("FAIL wrap_end: got valid=%b next_sn=%0d expected valid=0 next_sn=2", a_out_valid, a_next_sn);
    else n_pass++;
  endtask

  task automatic test_last_reset();
    do_reset();
    out_ready = 1'b0;
    q_a.push_back(mk_rec(0, 0, 1'b1));
    q_a.push_back(mk_rec(1, 1, 1'b1));
    set_lane(0, 0, 1'b1, 1'b0);
    set_lane(1, 1, 1'b1, 1'b0);
    in_last = '1;
    tick();
    clear_valid();
    in_last = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (a_out_valid !== 1'b1 || a_out_sn !== 4'd0 || a_out_last !== 1'b0)
        $display("FAIL last_hold[%0d]: got valid=%b sn=%0d last=%b expected 1/0/0", k, a_out_valid, a_out_sn, a_out_last);
      else n_pass++;
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (a_out_valid !== 1'b1 || a_out_sn !== 4'd1 || a_out_last !== 1'b0)
      $display("FAIL last_second: got valid=%b sn=%0d last=%b expected 1/1/0", a_out_valid, a_out_sn, a_out_last);
    else n_pass++;
    tick();
    n_checks++;
    if (a_out_valid !== 1'b0 || a_out_last !== 1'b0)
      $display("FAIL last_gap: got valid=%b last=%b expected 0/0", a_out_valid, a_out_last);
    else n_pass++;
    tick();
    n_checks++;
    if (a_out_last !== 1'b1 || a_in_ready !== 8'h00 || a_out_valid !== 1'b0 || a_next_sn !== 4'd2)
      $display("FAIL last_done: got last=%b ready=%h valid=%b next_sn=%0d expected 1/00/0/2",
               a_out_last, a_in_ready, a_out_valid, a_next_sn);
    else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (a_out_last !== 1'b0 || a_in_ready !== 8'hFF)
      $display("FAIL last_reset_done: got last=%b ready=%h expected 0/ff", a_out_last, a_in_ready);
    else n_pass++;

    do_reset();
    out_ready = 1'b0;
    q_a.push_back(mk_rec(0, 0, 1'b1));
    q_a.push_back(mk_rec(1, 1, 1'b1));
    set_lane(0, 0, 1'b1, 1'b0);
    set_lane(1, 1, 1'b1, 1'b0);
    in_last = '1;
    tick();
    clear_valid();
    in_last = '0;
    tick();
    n_checks++;
    if (a_out_valid !== 1'b1) $display("FAIL drain_loaded: got valid=%b expected 1", a_out_valid);
    else n_pass++;
    resetn = 1'b0;
    q_a.delete();
    #1;
    n_checks++;
    if (a_out_valid !== 1'b0 || a_out_last !== 1'b0 || a_next_sn !== 4'd0 || a_in_ready !== 8'hFF)
      $display("FAIL drain_reset: got valid=%b last=%b next_sn=%0d ready=%h expected 0/0/0/ff",
               a_out_valid, a_out_last, a_next_sn, a_in_ready);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    out_ready = 1'b1;
    q_a.push_back(mk_rec(3, 0, 1'b1));
    set_lane(3, 0, 1'b1, 1'b0);
    tick();
    clear_valid();
    tick();
    n_checks++;
    if (a_out_valid !== 1'b1 || a_out_sn !== 4'd0 || a_out_data !== mk_data(3, 0))
      $display("FAIL restart: got valid=%b sn=%0d data=%h expected 1/0/%h", a_out_valid, a_out_sn, a_out_data, mk_data(3, 0));
    else n_pass++;
    tick();
    n_checks++;
    if (a_out_valid !== 1'b0 || a_next_sn !== 4'd1)
      $display("FAIL restart_end: got valid=%b next_sn=%0d expected 0/1", a_out_valid, a_next_sn);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_reorder();
    test_backpressure();
    test_retire();
    test_emit();
    test_wrap();
    test_last_reset();
    n_checks++;
    if (q_a.size() != 0 || q_b.size() != 0)
      $display("FAIL scoreboard_drained: got %0d/%0d left expected 0/0", q_a.size(), q_b.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

endmodule
